// File: rtl/execute_unit_mc.sv
// Execute stage: width-generic ALU with registered outputs, plus an iterative
// multiply/divide unit with HI/LO registers behind a valid/ready handshake.
module execute_unit_mc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHAMT_W   = 5,
    parameter int unsigned MULDIV_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   alu_read_data_1,
    input  logic [WIDTH-1:0]   alu_read_data_2,
    input  logic [WIDTH-1:0]   immediate,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [5:0]         funct,
    input  logic [2:0]         alu_op,
    input  logic               alu_src,
    output logic               out_valid,
    output logic [WIDTH-1:0]   alu_result,
    output logic               zero,
    output logic               overflow,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam bit          MD_ON = (MULDIV_EN != 0);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MULDIV = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum_ab, dif_ab;
    logic             ovf_add, ovf_sub, lt_s, lt_u;
    logic [WIDTH-1:0] res_alu;
    logic             ovf_alu;
    logic             md_start, md_div, md_sgn;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Mult/div datapath: md_a holds multiplicand or divisor, md_hi the partial
    // product high half or remainder, md_lo the multiplier or quotient.
    logic [WIDTH-1:0] md_a_q, md_hi_q, md_lo_q;
    logic             md_div_q, neg_lo_q, neg_hi_q;
    logic [WIDTH:0]   mul_sum, div_rs, div_df;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fin_hi, fin_lo;
    logic             md_fire, alu_fire;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, valid_q;

    assign in_ready = (state_q != MULDIV);
    assign busy     = (state_q == MULDIV);
    assign accept   = in_valid && in_ready;

    // R-type always takes rt; otherwise alu_src selects the immediate.
    assign op_a = alu_read_data_1;
    assign op_b = (alu_op == 3'b010 || !alu_src) ? alu_read_data_2 : immediate;

    assign sum_ab  = op_a + op_b;
    assign dif_ab  = op_a - op_b;
    assign ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ab[WIDTH-1] != op_a[WIDTH-1]);
    assign ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_ab[WIDTH-1] != op_a[WIDTH-1]);
    assign lt_s    = $signed(op_a) < $signed(op_b);
    assign lt_u    = op_a < op_b;

    // Decode alu_op/funct into a single-cycle result or a mult/div launch.
    always_comb begin
        res_alu  = '0;
        ovf_alu  = 1'b0;
        md_start = 1'b0;
        md_div   = 1'b0;
        md_sgn   = 1'b0;
        unique case (alu_op)
            3'b000: res_alu = sum_ab;
            3'b001: res_alu = dif_ab;
            3'b010: begin
                case (funct)
                    F_ADD:   begin res_alu = sum_ab; ovf_alu = ovf_add; end
                    F_ADDU:  res_alu = sum_ab;
                    F_SUB:   begin res_alu = dif_ab; ovf_alu = ovf_sub; end
                    F_SUBU:  res_alu = dif_ab;
                    F_AND:   res_alu = op_a & op_b;
                    F_OR:    res_alu = op_a | op_b;
                    F_XOR:   res_alu = op_a ^ op_b;
                    F_NOR:   res_alu = ~(op_a | op_b);
                    F_SLT:   res_alu = {{(WIDTH-1){1'b0}}, lt_s};
                    F_SLTU:  res_alu = {{(WIDTH-1){1'b0}}, lt_u};
                    F_SLL:   res_alu = alu_read_data_2 << shamt;
                    F_SRL:   res_alu = alu_read_data_2 >> shamt;
                    F_SRA:   res_alu = $signed(alu_read_data_2) >>> shamt;
                    F_MULT:  begin md_start = MD_ON; md_sgn = 1'b1; end
                    F_MULTU: md_start = MD_ON;
                    F_DIV:   begin md_start = MD_ON; md_div = 1'b1; md_sgn = 1'b1; end
                    F_DIVU:  begin md_start = MD_ON; md_div = 1'b1; end
                    F_MFHI:  res_alu = MD_ON ? hi_q : '0;
                    F_MFLO:  res_alu = MD_ON ? lo_q : '0;
                    default: res_alu = '0;
                endcase
            end
            3'b011: res_alu = op_a & op_b;
            3'b100: res_alu = op_a | op_b;
            3'b101: res_alu = {{(WIDTH-1){1'b0}}, lt_s};
            3'b110: res_alu = op_b << (WIDTH / 2);
            3'b111: res_alu = '0;
        endcase
    end

    // Signed ops run on magnitudes; the sign is restored at the last step.
    assign sgn_a = md_sgn & op_a[WIDTH-1];
    assign sgn_b = md_sgn & op_b[WIDTH-1];
    assign mag_a = sgn_a ? -op_a : op_a;
    assign mag_b = sgn_b ? -op_b : op_b;

    // One shift-add or restoring shift-subtract step on the current registers.
    always_comb begin
        mul_sum = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_a_q} : '0);
        div_rs  = {md_hi_q, md_lo_q[WIDTH-1]};
        div_df  = div_rs - {1'b0, md_a_q};
        div_ok  = !div_df[WIDTH];
        if (md_div_q) begin
            step_hi = div_ok ? div_df[WIDTH-1:0] : div_rs[WIDTH-1:0];
            step_lo = {md_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], md_lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the final step's outcome.
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fix = neg_lo_q ? -prod_raw : prod_raw;
        quo_fix  = neg_lo_q ? -step_lo : step_lo;
        rem_fix  = neg_hi_q ? -step_hi : step_hi;
        fin_hi   = md_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = md_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    assign md_fire  = (state_q == MULDIV) && (cnt_q == '0);
    assign alu_fire = accept && !md_start;

    // FSM next state: IDLE/DONE accept, MULDIV runs until the counter expires.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = (accept && md_start) ? MULDIV : IDLE;
            MULDIV:     state_d = (cnt_q == '0) ? DONE : MULDIV;
            default:    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mult/div operand capture and iteration. Divide by zero leaves the
    // quotient unsigned (all ones) so only the remainder takes the dividend sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_a_q   <= '0;
            md_hi_q  <= '0;
            md_lo_q  <= '0;
            md_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && md_start) begin
            md_div_q <= md_div;
            md_hi_q  <= '0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            if (md_div) begin
                md_a_q   <= mag_b;
                md_lo_q  <= mag_a;
                neg_lo_q <= (sgn_a ^ sgn_b) && (op_b != '0);
                neg_hi_q <= sgn_a;
            end else begin
                md_a_q   <= mag_a;
                md_lo_q  <= mag_b;
                neg_lo_q <= sgn_a ^ sgn_b;
                neg_hi_q <= sgn_a ^ sgn_b;
            end
        end else if (state_q == MULDIV) begin
            md_hi_q <= step_hi;
            md_lo_q <= step_lo;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // HI/LO architectural registers, written on the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_fire) begin
            hi_q <= fin_hi;
            lo_q <= fin_lo;
        end
    end

    // Registered result/flags; held until another op completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (alu_fire) begin
            result_q <= res_alu;
            zero_q   <= (res_alu == '0);
            ovf_q    <= ovf_alu;
            valid_q  <= 1'b1;
        end else if (md_fire) begin
            result_q <= fin_lo;
            zero_q   <= (fin_lo == '0);
            ovf_q    <= 1'b0;
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign alu_result = result_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign out_valid  = valid_q;

endmodule
